// File: rtl/shift_left_multicycle.sv
// Iterative 16-bit left shifter/rotator: one barrel stage (1, 2, 4, 8) per clock, fixed 4-cycle latency.
// Define SHIFT_LEFT_ROTATE_EN to enable rotate-left on Op=1; otherwise every operation is a logical shift.
module shift_left_multicycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic        Op,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST0  = 3'd1,
    ST1  = 3'd2,
    ST2  = 3'd3,
    ST3  = 3'd4
  } state_e;

  state_e      state_q;
  logic [15:0] work_q;
  logic [15:0] work_d;
  logic [15:0] out_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        rot;

`ifdef SHIFT_LEFT_ROTATE_EN
  logic op_q;
  assign rot = op_q;
`else
  logic unused_op;
  assign unused_op = Op;
  assign rot       = 1'b0;
`endif

  // Stage k shifts by 2^k when cnt bit k is set; rotate wraps the bits shifted out back into the low end.
  always_comb begin
    work_d = work_q;
    case (state_q)
      ST0: if (cnt_q[0]) work_d = {work_q[14:0], rot ? work_q[15]    : 1'b0};
      ST1: if (cnt_q[1]) work_d = {work_q[13:0], rot ? work_q[15:14] : 2'b00};
      ST2: if (cnt_q[2]) work_d = {work_q[11:0], rot ? work_q[15:12] : 4'h0};
      ST3: if (cnt_q[3]) work_d = {work_q[7:0],  rot ? work_q[15:8]  : 8'h00};
      default: work_d = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      cnt_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 16'h0000;
`ifdef SHIFT_LEFT_ROTATE_EN
      op_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            work_q  <= In;
            cnt_q   <= Cnt;
`ifdef SHIFT_LEFT_ROTATE_EN
            op_q    <= Op;
`endif
            busy_q  <= 1'b1;
            state_q <= ST0;
          end
        end
        ST0: begin
          work_q  <= work_d;
          state_q <= ST1;
        end
        ST1: begin
          work_q  <= work_d;
          state_q <= ST2;
        end
        ST2: begin
          work_q  <= work_d;
          state_q <= ST3;
        end
        ST3: begin
          work_q  <= work_d;
          out_q   <= work_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Out  = out_q;

endmodule

// File: tb/tb_shift_left_multicycle.sv
// Self-checking bench for shift_left_multicycle: cycle-level reference model plus directed vectors.
// Expectations follow SHIFT_LEFT_ROTATE_EN the same way the design does.
module tb_shift_left_multicycle;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic        Op;
  logic        Busy;
  logic        Done;
  logic [15:0] Out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef SHIFT_LEFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  shift_left_multicycle dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .In    (In),
    .Cnt   (Cnt),
    .Op    (Op),
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-shift reference: shift in a 32-bit word, the upper half holds the bits that fell off.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] c, input logic o);
    logic [31:0] w;
    w = {16'h0000, a} << c;
    if (o && ROT_EN) return w[15:0] | w[31:16];
    return w[15:0];
  endfunction

  // Transaction-level model: an accepted start produces its result 4 edges later.
  int          m_rem  = 0;
  logic [15:0] m_res  = 16'h0000;
  logic [15:0] m_out  = 16'h0000;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  = 0;
      m_out  = 16'h0000;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_out  = m_res;
          m_done = 1'b1;
        end
      end else if (Start) begin
        m_res = ref_shift(In, Cnt, Op);
        m_rem = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {15'h0, Busy}, {15'h0, (m_rem != 0)});
      check("model_done", {15'h0, Done}, {15'h0, m_done});
      check("model_out", Out, m_out);
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the Done cycle (or on timeout).
  task automatic do_op(input string nm, input logic [15:0] a, input logic [3:0] c, input logic o,
                       input logic [15:0] exp, input bit busy_start);
    int n;
    int busy_n;
    Start = 1'b1;
    In    = a;
    Cnt   = c;
    Op    = o;
    @(negedge clk);
    n      = 1;
    busy_n = 0;
    while (Done !== 1'b1 && n < 10) begin
      if (Busy === 1'b1) busy_n++;
      Start = busy_start;
      In    = 16'($urandom);
      Cnt   = 4'($urandom);
      Op    = 1'($urandom);
      @(negedge clk);
      n++;
    end
    Start = 1'b0;
    check({nm, "_latency"}, 16'(n), 16'd5);
    check({nm, "_busy_cycles"}, 16'(busy_n), 16'd4);
    check({nm, "_busy_in_done"}, {15'h0, Busy}, 16'h0000);
    check({nm, "_out"}, Out, exp);
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    In    = 16'h0000;
    Cnt   = 4'h0;
    Op    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {15'h0, Busy}, 16'h0000);
    check("reset_done", {15'h0, Done}, 16'h0000);
    check("reset_out", Out, 16'h0000);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    // Pin the model itself against hand-computed values.
    check("ref_pin_rot", ref_shift(16'h8001, 4'd1, 1'b1), ROT_EN ? 16'h0003 : 16'h0002);
    check("ref_pin_max", ref_shift(16'hFFFF, 4'd15, 1'b0), 16'h8000);

    do_op("shl8", 16'h00FF, 4'd8, 1'b0, 16'hFF00, 1'b0);
    @(negedge clk);
    do_op("rot1", 16'h8001, 4'd1, 1'b1, ROT_EN ? 16'h0003 : 16'h0002, 1'b0);
    do_op("rot4", 16'hF00F, 4'd4, 1'b1, ROT_EN ? 16'h00FF : 16'h00F0, 1'b0);
    do_op("cnt0", 16'h1234, 4'd0, 1'b0, 16'h1234, 1'b0);
    do_op("cnt15", 16'hFFFF, 4'd15, 1'b0, 16'h8000, 1'b0);
    @(negedge clk);

    // Start held high while busy must be ignored; a start in the Done cycle is accepted.
    do_op("ignore", 16'h0001, 4'd2, 1'b0, 16'h0004, 1'b1);
    do_op("b2b", 16'h0003, 4'd1, 1'b0, 16'h0006, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out", Out, 16'h0006);
      check("idle_done", {15'h0, Done}, 16'h0000);
      check("idle_busy", {15'h0, Busy}, 16'h0000);
    end

    do_op("pre_abort", 16'h0001, 4'd2, 1'b0, 16'h0004, 1'b0);
    Start = 1'b1;
    In    = 16'h1234;
    Cnt   = 4'd3;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {15'h0, Busy}, 16'h0000);
    check("abort_out", Out, 16'h0000);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (Done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", {15'h0, seen}, 16'h0000);
    end
    check("abort_out_hold", Out, 16'h0000);

    // rst wins over a simultaneous Start.
    Start = 1'b1;
    rst   = 1'b1;
    In    = 16'h5555;
    Cnt   = 4'd1;
    @(negedge clk);
    Start = 1'b0;
    rst   = 1'b0;
    check("rst_start_busy", {15'h0, Busy}, 16'h0000);
    repeat (5) @(negedge clk);
    check("rst_start_out", Out, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
